// File: rtl/control_fsm_if.sv
// control_fsm_if: control bundle between the multi-cycle control unit and the RV32I datapath.
//   instr     current instruction word (held stable from IF through WB)
//   Zero      ALU zero flag from the datapath
//   memReady  data memory has completed the access requested in MEM
//   PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite  datapath controls
//   instret   retired-instruction count
// The master modport is the control unit; the slave modport is the datapath side.
interface control_fsm_if;
  logic [31:0] instr;
  logic        Zero;
  logic        memReady;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] instret;

  modport master (
    input  instr, Zero, memReady,
    output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, instret
  );

  modport slave (
    output instr, Zero, memReady,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, instret
  );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control unit. Sequences each instruction through
// IF -> ID -> EX -> MEM -> WB, holding MEM for LW/SW until memReady, and drives the
// datapath controls as Moore outputs of the state gated by instruction decode.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  control_fsm_if.master (instr/Zero/memReady in; controls and instret out)
module control_fsm (
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.master bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb} state_e;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_r, is_i, is_lw, is_sw, is_beq;
  logic       unused_instr;

  assign opcode    = bus.instr[6:0];
  assign funct3    = bus.instr[14:12];
  assign funct7_b5 = bus.instr[30];
  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  assign is_r   = (opcode == OpR);
  assign is_i   = (opcode == OpI);
  assign is_lw  = (opcode == OpLw);
  assign is_sw  = (opcode == OpSw);
  assign is_beq = (opcode == OpBeq);

  // ALU decode is purely combinational from instr, valid in every state.
  always_comb begin
    bus.ALUCtrl = ALU_ADD;
    bus.ALUSrc  = 1'b0;
    if (is_r || is_i) begin
      bus.ALUSrc = is_i;
      unique case (funct3)
        3'b000:  bus.ALUCtrl = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b111:  bus.ALUCtrl = ALU_AND;
        3'b110:  bus.ALUCtrl = ALU_OR;
        3'b100:  bus.ALUCtrl = ALU_XOR;
        3'b010:  bus.ALUCtrl = ALU_SLT;
        3'b001:  bus.ALUCtrl = ALU_SLL;
        3'b101:  bus.ALUCtrl = funct7_b5 ? ALU_SRA : ALU_SRL;
        default: bus.ALUCtrl = ALU_ADD;
      endcase
    end else if (is_lw || is_sw) begin
      bus.ALUSrc = 1'b1;
    end else if (is_beq) begin
      bus.ALUCtrl = ALU_SUB;
    end
  end

  assign bus.MemToReg = is_lw;

  // Next state, Moore strobes and retire count.
  always_comb begin
    state_d      = state_q;
    instret_d    = instret_q;
    bus.RegWrite = 1'b0;
    bus.loadPC   = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.PCSrc    = 1'b0;
    unique case (state_q)
      StIf: state_d = StId;
      StId: state_d = StEx;
      StEx: state_d = StMem;
      StMem: begin
        bus.MemRead  = is_lw;
        bus.MemWrite = is_sw;
        // Only memory ops wait; memReady is ignored for everything else.
        if (!(is_lw || is_sw) || bus.memReady) begin
          state_d = StWb;
        end
      end
      StWb: begin
        bus.RegWrite = is_r || is_i || is_lw;
        bus.loadPC   = 1'b1;
        bus.PCSrc    = is_beq && bus.Zero;
        state_d      = StIf;
        instret_d    = instret_q + 32'd1;
      end
      default: state_d = StIf;
    endcase
  end

  assign bus.instret = instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIf;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed bench for control_fsm. A decode table checks ALUCtrl/ALUSrc/MemToReg;
// hand-written sequences check per-instruction strobe timing, memory waits, reset abort and
// instret wrap.
module tb_control_fsm;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_fsm_if bus ();

  control_fsm dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_instret = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        src;
    logic        mtr;
  } dec_vec_t;

  dec_vec_t vecs[19];

  function automatic logic [4:0] strobes();
    return {bus.RegWrite, bus.loadPC, bus.MemRead, bus.MemWrite, bus.PCSrc};
  endfunction

  // Runs one instruction starting just after a rising edge with the FSM in IF.
  // memReady rises on MEM cycle number waits+1 (only while a memory strobe is up).
  task automatic run_instr(input logic [31:0] ins, input logic z, input int waits,
                           output int cycles, output int n_rd, output int n_wr,
                           output int n_rw, output int n_rw_wb, output int n_pcs,
                           output int n_pcs_wb);
    int mem_cnt;
    mem_cnt = 0;
    cycles = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_rw_wb = 0; n_pcs = 0; n_pcs_wb = 0;
    bus.instr = ins;
    bus.Zero = z;
    bus.memReady = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_rd += int'(bus.MemRead);
      n_wr += int'(bus.MemWrite);
      n_rw += int'(bus.RegWrite);
      n_pcs += int'(bus.PCSrc);
      if (bus.MemRead || bus.MemWrite) begin
        bus.memReady = (mem_cnt == waits);
        mem_cnt++;
      end else begin
        bus.memReady = 1'b0;
      end
      if (bus.loadPC) begin
        cycles = c;
        n_rw_wb = int'(bus.RegWrite);
        n_pcs_wb = int'(bus.PCSrc);
        @(posedge clk);
        #1;
        bus.memReady = 1'b0;
        return;
      end
    end
    check("instr_timeout", 32'd1, 32'd0);
  endtask

  int cyc, rd, wr, rw, rw_wb, pcs, pcs_wb;

  initial begin
    vecs[0]  = '{32'h40B50533, 4'b0110, 1'b0, 1'b0};  // sub
    vecs[1]  = '{32'h4020D093, 4'b1010, 1'b1, 1'b0};  // srai
    vecs[2]  = '{32'h00A00093, 4'b0010, 1'b1, 1'b0};  // addi
    vecs[3]  = '{32'h00B50533, 4'b0010, 1'b0, 1'b0};  // add
    vecs[4]  = '{32'h00B57533, 4'b0000, 1'b0, 1'b0};  // and
    vecs[5]  = '{32'h00B56533, 4'b0001, 1'b0, 1'b0};  // or
    vecs[6]  = '{32'h00B54533, 4'b1101, 1'b0, 1'b0};  // xor
    vecs[7]  = '{32'h00B52533, 4'b0111, 1'b0, 1'b0};  // slt
    vecs[8]  = '{32'h00B51533, 4'b1001, 1'b0, 1'b0};  // sll
    vecs[9]  = '{32'h00B55533, 4'b1000, 1'b0, 1'b0};  // srl
    vecs[10] = '{32'h40B55533, 4'b1010, 1'b0, 1'b0};  // sra
    vecs[11] = '{32'h40000093, 4'b0010, 1'b1, 1'b0};  // addi, bit30 set: still ADD
    vecs[12] = '{32'h0020D093, 4'b1000, 1'b1, 1'b0};  // srli
    vecs[13] = '{32'h00F0C093, 4'b1101, 1'b1, 1'b0};  // xori
    vecs[14] = '{32'h00F0F093, 4'b0000, 1'b1, 1'b0};  // andi
    vecs[15] = '{32'h0002A303, 4'b0010, 1'b1, 1'b1};  // lw
    vecs[16] = '{32'h0062A023, 4'b0010, 1'b1, 1'b0};  // sw
    vecs[17] = '{32'h00208463, 4'b0110, 1'b0, 1'b0};  // beq
    vecs[18] = '{32'h0000007F, 4'b0010, 1'b0, 1'b0};  // illegal

    rst = 1'b0;
    bus.instr = 32'h00B50533;
    bus.Zero = 1'b0;
    bus.memReady = 1'b0;

    // Reset hold: strobes low and count zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_strobes", {27'd0, strobes()}, 32'd0);
      check("reset_instret", bus.instret, 32'd0);
    end

    // Decode is combinational and valid in any state, including reset.
    for (int i = 0; i < 19; i++) begin
      bus.instr = vecs[i].instr;
      #1;
      check($sformatf("dec_alu[%0d]", i), {28'd0, bus.ALUCtrl}, {28'd0, vecs[i].alu});
      check($sformatf("dec_src[%0d]", i), {31'd0, bus.ALUSrc}, {31'd0, vecs[i].src});
      check($sformatf("dec_mtr[%0d]", i), {31'd0, bus.MemToReg}, {31'd0, vecs[i].mtr});
    end

    @(posedge clk);
    #1;
    rst = 1'b1;

    // ADD after release: 5 cycles, writes only in WB.
    run_instr(32'h00B50533, 1'b0, 0, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    exp_instret++;
    check("add_cycles", cyc, 5);
    check("add_rw", rw, 1);
    check("add_rw_wb", rw_wb, 1);
    check("add_mem", rd + wr, 0);
    check("add_instret", bus.instret, exp_instret);

    // LW with 3 wait cycles.
    run_instr(32'h0002A303, 1'b0, 3, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    exp_instret++;
    check("lw_cycles", cyc, 8);
    check("lw_rd", rd, 4);
    check("lw_wr", wr, 0);
    check("lw_rw_wb", rw + rw_wb, 2);
    check("lw_instret", bus.instret, exp_instret);

    // SW with zero wait.
    run_instr(32'h0062A023, 1'b0, 0, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    exp_instret++;
    check("sw_cycles", cyc, 5);
    check("sw_wr", wr, 1);
    check("sw_rd", rd, 0);
    check("sw_rw", rw, 0);

    // BEQ taken: PCSrc only in WB alongside loadPC, though Zero is high throughout.
    run_instr(32'h00208463, 1'b1, 0, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    exp_instret++;
    check("beq_t_cycles", cyc, 5);
    check("beq_t_pcs", pcs, 1);
    check("beq_t_pcs_wb", pcs_wb, 1);
    check("beq_t_rw", rw, 0);

    run_instr(32'h00208463, 1'b0, 0, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    exp_instret++;
    check("beq_nt_pcs", pcs, 0);
    check("beq_nt_cycles", cyc, 5);

    // Illegal opcode: full sequence, no writes, PC+4 even with Zero high.
    run_instr(32'h0000007F, 1'b1, 0, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    exp_instret++;
    check("ill_cycles", cyc, 5);
    check("ill_strobes", rd + wr + rw + pcs, 0);
    check("ill_instret", bus.instret, exp_instret);

    // Abort an SW in MEM: the strobe drops with no clock edge, no WB happens.
    bus.instr = 32'h0062A023;
    bus.Zero = 1'b0;
    bus.memReady = 1'b0;
    rw = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      rw += int'(bus.loadPC) + int'(bus.RegWrite);
    end
    check("abort_memwrite_before", {31'd0, bus.MemWrite}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("abort_memwrite_after", {31'd0, bus.MemWrite}, 32'd0);
    check("abort_no_wb", rw, 0);
    exp_instret = 32'd0;
    check("abort_instret", bus.instret, exp_instret);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_instr(32'h00B50533, 1'b0, 0, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    exp_instret++;
    check("post_abort_cycles", cyc, 5);
    check("post_abort_instret", bus.instret, exp_instret);

    // Wrap: preload the counter to all ones, retire one instruction.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    check("wrap_preload", bus.instret, 32'hFFFF_FFFF);
    run_instr(32'h00A00093, 1'b0, 0, cyc, rd, wr, rw, rw_wb, pcs, pcs_wb);
    check("wrap_instret", bus.instret, 32'd0);
    check("wrap_cycles", cyc, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the RV32I core: decodes the current instruction word and sequences it through five fixed phases, driving the datapath's mux selects, ALU operation, register-file write, data-memory strobes and PC update. Sits directly upstream of the datapath; its outputs connect one-to-one to the datapath control inputs, and it consumes the datapath's Zero flag. Adds a data-memory ready handshake and a retired-instruction counter.

## Interface
- ALU_ADD: 4'b0010. ALUCtrl code for add.
- ALU_SUB: 4'b0110. ALUCtrl code for subtract.
- Other ALUCtrl codes are fixed, not parameters: AND 4'b0000, OR 4'b0001, SLT 4'b0111, SRL 4'b1000, SLL 4'b1001, SRA 4'b1010, XOR 4'b1101.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  32  current instruction word; stable from IF through WB.
- Zero  in  1  ALU zero flag from the datapath.
- memReady  in  1  data memory has completed the access requested in MEM.
- PCSrc  out  1  1 selects the branch target, 0 selects PC+4.
- ALUSrc  out  1  1 selects the immediate as ALU operand 2.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  1 selects dReadData for write-back.
- ALUCtrl  out  4  ALU operation.
- loadPC  out  1  PC update strobe.
- MemRead  out  1  data-memory read strobe.
- MemWrite  out  1  data-memory write strobe.
- instret  out  32  count of retired instructions.

## Operation
- State register with five states: IF, ID, EX, MEM, WB.
- Transitions: IF→ID→EX→MEM, then MEM→WB.
  - For LW and SW, MEM holds until memReady=1; all other instructions leave MEM unconditionally.
  - WB→IF.
- Supported opcodes:
  - R-type 0110011.
  - I-ALU 0010011.
  - LW 0000011.
  - SW 0100011.
  - BEQ 1100011.
  - Any other opcode is illegal: it runs the full sequence with RegWrite, MemRead and MemWrite never asserted, and the PC advances by 4.
- ALUCtrl and ALUSrc are combinational from instr and are valid in every state:
  - R-type: funct3/funct7[5] select the operation. 000 gives ADD, or SUB when funct7[5]=1. 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL. 101 gives SRL, or SRA when funct7[5]=1.
  - I-ALU: same mapping, except funct3=000 is always ADD; funct7[5] is honoured only for 101. ALUSrc=1.
  - LW/SW: ADD, ALUSrc=1.
  - BEQ: SUB, ALUSrc=0.
  - Illegal: ADD, ALUSrc=0.
- MemToReg=1 only for LW; 0 otherwise.
- MemRead=1 only in MEM for LW; MemWrite=1 only in MEM for SW. Both stay high for every MEM cycle, including wait cycles.
- RegWrite=1 only in WB, and only for R-type, I-ALU and LW.
- loadPC=1 only in WB, for every instruction.
- PCSrc is meaningful only in WB and equals (opcode==BEQ) & Zero. It is 0 in every other state.
- instr[11:7]=0 writes are still signalled; the register file discards them.
- instret increments by 1 on the clock edge leaving WB. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (rst=0) acts asynchronously and forces:
  - state to IF;
  - instret to 0;
  - every strobe low: RegWrite, loadPC, MemRead, MemWrite, PCSrc.
- Reset mid-instruction abandons that instruction: no RegWrite, no loadPC, and the memory strobes drop immediately.
- Release of rst is sampled on the next rising edge; the first IF cycle follows.
- Latency: 5 cycles per non-memory instruction; 5+N cycles for LW/SW, where N is the number of MEM cycles with memReady=0.
- memReady=1 in the first MEM cycle gives zero wait. memReady is ignored outside MEM and for non-memory opcodes.
- All strobes are Moore outputs of the state, gated by decode of instr. They are glitch-free provided instr is stable.
- Zero is sampled combinationally during WB. The PC edge at the end of WB uses it.

## Test plan
- Reset: hold rst=0 for 3 cycles with instr=ADD → RegWrite, loadPC, MemRead, MemWrite and PCSrc all 0, instret=0. After release, the state runs IF through WB in 5 cycles, with loadPC and RegWrite high only in cycle 5.
- R/I decode: instr=0x40B50533 (sub x10,x10,x11) → ALUCtrl=0110, ALUSrc=0. instr=0x4020D093 (srai x1,x1,2) → ALUCtrl=1010, ALUSrc=1. instr=0x00A00093 (addi) → ALUCtrl=0010.
- LW with wait: instr=0x0002A303 (lw x6,0(x5)), memReady low for 3 MEM cycles → MemRead high for 4 cycles, MemToReg=1, RegWrite for one WB cycle, total 8 cycles, instret+1.
- SW: instr=0x0062A023 (sw x6,0(x5)), memReady=1 → MemWrite high for exactly 1 cycle, RegWrite never high, 5 cycles total.
- BEQ: instr=0x00208463. Zero=1 in WB → PCSrc=1 with loadPC. Zero=0 → PCSrc=0. ALUCtrl=0110 in both cases.
- Abort and wrap: assert rst=0 mid-MEM of an SW → MemWrite drops immediately with no clock edge, and no WB occurs. Separately, force instret to 0xFFFFFFFF, retire one instruction → instret=0.
